mesh_term_injector: RTL and testbench
=====================================

MESH_TERM_INJECTOR -- requirements
Module: mesh_term_injector

Interface
REQ-001 SHALL have parameter ROWS, default 4, mesh router rows.
REQ-002 SHALL have parameter COLUMS, default 4, mesh router columns.
REQ-003 SHALL have parameter pckg_sz, default 40, packet width in bits.
REQ-004 SHALL have parameter fifo_depth, default 4, entries per terminal FIFO (power of two, >=2).
REQ-005 SHALL have parameter bdcst, default {8{1'b1}}, broadcast destination id {row,colum}.
REQ-006 SHALL derive local DRVS = ROWS*2+COLUMS*2; terminal i owns slice [i*pckg_sz +: pckg_sz] of flattened buses.
REQ-007 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-008 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-009 SHALL have port push, input, DRVS, per-terminal write strobe from bench/traffic source.
REQ-010 SHALL have port wr_data, input, DRVS*pckg_sz, per-terminal packet to enqueue.
REQ-011 SHALL have port gap, input, 4, idle cycles forced after each pop (0 = back-to-back).
REQ-012 SHALL have port pndng_i_in, output, DRVS, head packet valid toward mesh terminal.
REQ-013 SHALL have port data_out_i_in, output, DRVS*pckg_sz, head packet toward mesh terminal.
REQ-014 SHALL have port popin, input, DRVS, mesh pop of head packet.
REQ-015 SHALL have port full, output, DRVS, FIFO full flag.
REQ-016 SHALL have port count, output, DRVS*($clog2(fifo_depth)+1), per-terminal occupancy.
REQ-017 SHALL have ports drop_cnt and err_cnt, output, 8 each, saturating totals over all terminals.

Function
REQ-018 Packet fields SHALL be Nxtjp [pckg_sz-1:pckg_sz-8], row [pckg_sz-9:pckg_sz-12], colum [pckg_sz-13:pckg_sz-16], mode [pckg_sz-17], payload [pckg_sz-18:0]; stored unmodified.
REQ-019 Destination SHALL be valid iff {row,colum}==bdcst, or row in {0,ROWS+1} with colum 1..COLUMS, or colum in {0,COLUMS+1} with row 1..ROWS.
REQ-020 push with invalid destination SHALL not enqueue; err_cnt +1 that cycle (saturate at 255).
REQ-021 push with valid destination while full and no same-cycle pop SHALL not enqueue; drop_cnt +1 (saturate at 255).
REQ-022 Valid push while full with same-cycle accepted pop SHALL enqueue; count unchanged.
REQ-023 FIFO SHALL be show-ahead: data_out_i_in = head entry whenever pndng_i_in=1; enqueue-to-pndng latency 1 cycle.
REQ-024 Per-terminal FSM states IDLE (empty), SEND (pndng_i_in=1), HOLD (gap countdown, pndng_i_in=0).
REQ-025 IDLE->SEND when count becomes nonzero; SEND+popin: removes head; ->HOLD if gap!=0, else stay SEND if entries remain, else IDLE.
REQ-026 HOLD SHALL last exactly gap cycles (value sampled at pop); then ->SEND if count>0, else IDLE.
REQ-027 popin while pndng_i_in=0 SHALL be ignored (no pointer/count change).
REQ-028 Read/write pointers SHALL wrap modulo fifo_depth; count range 0..fifo_depth; full = (count==fifo_depth).
REQ-029 Multiple terminals pushing invalid/overflow in one cycle SHALL add the number of such events to the counters (saturating).
REQ-030 Terminals SHALL be independent; no cross-channel arbitration or ordering.

Reset
REQ-031 reset=1 at a clock edge SHALL empty all FIFOs, set FSMs to IDLE, pndng_i_in=0, full=0, count=0, drop_cnt=0, err_cnt=0, data_out_i_in=0.
REQ-032 reset mid-transfer SHALL discard queued packets; push/popin in the reset cycle ignored.

Verification
REQ-033 4x4, pckg_sz=40: push[0] wr_data=40'h0002800001 (row0 col2 mode1 payload1), gap=0 -> next cycle pndng_i_in[0]=1, data_out_i_in[0]=40'h0002800001; popin -> pndng 0, count 0.
REQ-034 push[3] wr_data=40'h0000800001 (row0 col0) -> not queued, err_cnt=1, pndng_i_in[3]=0.
REQ-035 5 valid pushes to terminal 1, no pops -> count=4, full=1, drop_cnt=1; 5th push with same-cycle popin -> accepted, drop_cnt stays 0.
REQ-036 gap=3, two queued packets, popin held 1 -> pndng_i_in low exactly 3 cycles between the two packets, order preserved.
REQ-037 wr_data with {row,colum}=8'hFF -> accepted as broadcast; fill/drain 9 packets -> pointer wrap, FIFO order intact.
REQ-038 reset asserted with 3 queued on terminal 5 -> next cycle count=0, pndng_i_in=0, counters 0.

Source files
------------

// File: rtl/mesh_term_injector.sv
// Mesh terminal injector: one show-ahead FIFO per mesh edge terminal, with
// destination filtering, an inter-packet gap after each pop, and saturating
// totals of rejected (bad destination) and dropped (overflow) pushes.
module mesh_term_injector #(
  parameter int          ROWS       = 4,
  parameter int          COLUMS     = 4,
  parameter int          pckg_sz    = 40,
  parameter int          fifo_depth = 4,
  parameter logic [7:0]  bdcst      = {8{1'b1}},
  localparam int         DRVS       = ROWS*2 + COLUMS*2,
  localparam int         CW         = $clog2(fifo_depth) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DRVS-1:0]         push,
  input  logic [DRVS*pckg_sz-1:0] wr_data,
  input  logic [3:0]              gap,
  output logic [DRVS-1:0]         pndng_i_in,
  output logic [DRVS*pckg_sz-1:0] data_out_i_in,
  input  logic [DRVS-1:0]         popin,
  output logic [DRVS-1:0]         full,
  output logic [DRVS*CW-1:0]      count,
  output logic [7:0]              drop_cnt,
  output logic [7:0]              err_cnt
);

  localparam int AW = $clog2(fifo_depth);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [3:0] R_MAX  = 4'(ROWS);
  localparam logic [3:0] C_MAX  = 4'(COLUMS);
  localparam logic [3:0] R_LAST = 4'(ROWS + 1);
  localparam logic [3:0] C_LAST = 4'(COLUMS + 1);

  logic [DRVS-1:0] w_err;
  logic [DRVS-1:0] w_drop;

  for (genvar g = 0; g < DRVS; g++) begin : g_term
    logic [pckg_sz-1:0] r_mem [fifo_depth];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic [CW-1:0]      w_count_nxt;
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [3:0]         r_hold;
    logic [3:0]         w_hold_nxt;
    logic [3:0]         w_row;
    logic [3:0]         w_col;
    logic               w_dst_ok;
    logic               w_full;
    logic               w_pop;
    logic               w_wr;

    assign w_row = wr_data[g*pckg_sz + pckg_sz - 9  -: 4];
    assign w_col = wr_data[g*pckg_sz + pckg_sz - 13 -: 4];

    // Destination is broadcast or a terminal position on the mesh border
    assign w_dst_ok = ({w_row, w_col} == bdcst)
                    | (((w_row == 4'd0) | (w_row == R_LAST)) & (w_col >= 4'd1) & (w_col <= C_MAX))
                    | (((w_col == 4'd0) | (w_col == C_LAST)) & (w_row >= 4'd1) & (w_row <= R_MAX));

    assign w_full      = (r_count == CW'(fifo_depth));
    assign w_pop       = popin[g] & (r_state == S_SEND);
    // A pop in the same cycle frees the slot a full FIFO needs
    assign w_wr        = push[g] & w_dst_ok & (~w_full | w_pop);
    assign w_err[g]    = push[g] & ~w_dst_ok;
    assign w_drop[g]   = push[g] & w_dst_ok & w_full & ~w_pop;
    assign w_count_nxt = r_count + CW'(w_wr) - CW'(w_pop);

    // Next-state: entering SEND on the write itself gives one-cycle visibility
    always_comb begin
      w_state_nxt = r_state;
      w_hold_nxt  = r_hold;
      case (r_state)
        S_IDLE: begin
          if (w_wr) w_state_nxt = S_SEND;
        end
        S_SEND: begin
          if (w_pop) begin
            if (gap != 4'd0) begin
              w_state_nxt = S_HOLD;
              w_hold_nxt  = gap;
            end else if (w_count_nxt != '0) begin
              w_state_nxt = S_SEND;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end
        S_HOLD: begin
          if (r_hold <= 4'd1) begin
            w_state_nxt = (w_count_nxt != '0) ? S_SEND : S_IDLE;
            w_hold_nxt  = '0;
          end else begin
            w_hold_nxt  = r_hold - 4'd1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end

    // Pointers, occupancy and FSM state
    always_ff @(posedge clk) begin
      if (reset) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
        r_state  <= S_IDLE;
        r_hold   <= '0;
      end else begin
        if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
        r_count <= w_count_nxt;
        r_state <= w_state_nxt;
        r_hold  <= w_hold_nxt;
      end
    end

    // Packet storage; contents are don't-care until pointed to
    always_ff @(posedge clk) begin
      if (!reset && w_wr) r_mem[r_wr_ptr] <= wr_data[g*pckg_sz +: pckg_sz];
    end

    assign pndng_i_in[g]                      = (r_state == S_SEND);
    assign data_out_i_in[g*pckg_sz +: pckg_sz] = (r_state == S_SEND) ? r_mem[r_rd_ptr] : '0;
    assign full[g]                            = w_full;
    assign count[g*CW +: CW]                  = r_count;
  end

  logic [15:0] w_err_n;
  logic [15:0] w_drop_n;
  logic [15:0] w_err_sum;
  logic [15:0] w_drop_sum;

  // Number of error / overflow events across all terminals this cycle
  always_comb begin
    w_err_n  = '0;
    w_drop_n = '0;
    for (int unsigned i = 0; i < DRVS; i++) begin
      w_err_n  = w_err_n  + 16'(w_err[i]);
      w_drop_n = w_drop_n + 16'(w_drop[i]);
    end
    w_err_sum  = {8'd0, err_cnt}  + w_err_n;
    w_drop_sum = {8'd0, drop_cnt} + w_drop_n;
  end

  // Saturating global counters
  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      err_cnt  <= (w_err_sum  > 16'd255) ? 8'd255 : w_err_sum[7:0];
      drop_cnt <= (w_drop_sum > 16'd255) ? 8'd255 : w_drop_sum[7:0];
    end
  end

endmodule

// File: tb/tb_mesh_term_injector.sv
// Scoreboard bench for mesh_term_injector (default 4x4 mesh, 40-bit packets).
module tb_mesh_term_injector;
  localparam int N  = 16;
  localparam int W  = 40;
  localparam int CW = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   push;
  logic [N*W-1:0] wr_data;
  logic [3:0]     gap;
  logic [N-1:0]   pndng;
  logic [N*W-1:0] dout;
  logic [N-1:0]   popin;
  logic [N-1:0]   full;
  logic [N*CW-1:0] count;
  logic [7:0]     drop_cnt;
  logic [7:0]     err_cnt;

  logic [W-1:0] sb [N][$];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mesh_term_injector #(.ROWS(4), .COLUMS(4), .pckg_sz(40), .fifo_depth(4)) dut (
    .clk(clk), .reset(reset), .push(push), .wr_data(wr_data), .gap(gap),
    .pndng_i_in(pndng), .data_out_i_in(dout), .popin(popin), .full(full),
    .count(count), .drop_cnt(drop_cnt), .err_cnt(err_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] mkpkt(input logic [3:0] r, input logic [3:0] c, input logic [22:0] pl);
    return {8'h00, r, c, 1'b1, pl};
  endfunction

  function automatic logic [CW-1:0] cnt(input int t);
    return count[t*CW +: CW];
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    push  = '0;
    popin = '0;
    tick();
    reset = 1'b0;
    for (int t = 0; t < N; t++) sb[t].delete();
  endtask

  task automatic do_push(input int t, input logic [W-1:0] d, input bit acc);
    push[t] = 1'b1;
    wr_data[t*W +: W] = d;
    if (acc) sb[t].push_back(d);
    tick();
    push = '0;
  endtask

  // Compare the shown head against the scoreboard, then pop it
  task automatic pop_head(input int t, input string tag);
    logic [W-1:0] e;
    check({tag, "_pnd"}, 64'(pndng[t]), 64'd1);
    check({tag, "_sbnonempty"}, 64'(sb[t].size() != 0), 64'd1);
    e = (sb[t].size() != 0) ? sb[t].pop_front() : '0;
    check({tag, "_data"}, 64'(dout[t*W +: W]), 64'(e));
    popin[t] = 1'b1;
    tick();
    popin = '0;
  endtask

  initial begin
    int popped;
    int lows;
    reset   = 1'b0;
    push    = '0;
    popin   = '0;
    wr_data = '0;
    gap     = 4'd0;
    tick();
    do_reset();

    // Reset state
    check("rst_pndng", 64'(pndng), 64'd0);
    check("rst_full",  64'(full),  64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_drop",  64'(drop_cnt), 64'd0);
    check("rst_err",   64'(err_cnt),  64'd0);
    check("rst_dout",  64'(dout == '0), 64'd1);

    // Single valid packet, one-cycle latency, then drained
    do_push(0, 40'h0002800001, 1'b1);
    check("t0_cnt1", 64'(cnt(0)), 64'd1);
    pop_head(0, "t0_pop");
    check("t0_pnd0", 64'(pndng[0]), 64'd0);
    check("t0_cnt0", 64'(cnt(0)), 64'd0);

    // Invalid destination (row0 col0)
    do_push(3, 40'h0000800001, 1'b0);
    check("t3_err", 64'(err_cnt), 64'd1);
    check("t3_pnd", 64'(pndng[3]), 64'd0);
    check("t3_cnt", 64'(cnt(3)), 64'd0);

    // Overflow without pop
    do_reset();
    for (int k = 0; k < 4; k++) do_push(1, mkpkt(4'd0, 4'(k + 1), 23'(16 + k)), 1'b1);
    check("ov_cnt4", 64'(cnt(1)), 64'd4);
    check("ov_full", 64'(full[1]), 64'd1);
    do_push(1, mkpkt(4'd5, 4'd1, 23'd99), 1'b0);
    check("ov_drop", 64'(drop_cnt), 64'd1);
    check("ov_cnt", 64'(cnt(1)), 64'd4);
    for (int k = 0; k < 4; k++) pop_head(1, "ov_drain");
    check("ov_empty", 64'(cnt(1)), 64'd0);

    // Full with simultaneous pop accepts the push
    do_reset();
    for (int k = 0; k < 4; k++) do_push(1, mkpkt(4'd1, 4'd0, 23'(32 + k)), 1'b1);
    begin
      logic [W-1:0] e;
      e = sb[1].pop_front();
      check("fp_head", 64'(dout[1*W +: W]), 64'(e));
      popin[1] = 1'b1;
      do_push(1, mkpkt(4'd2, 4'd5, 23'd77), 1'b1);
      popin = '0;
    end
    check("fp_cnt", 64'(cnt(1)), 64'd4);
    check("fp_full", 64'(full[1]), 64'd1);
    check("fp_drop", 64'(drop_cnt), 64'd0);
    for (int k = 0; k < 4; k++) pop_head(1, "fp_drain");

    // Gap of 3 between two packets with popin held high
    gap = 4'd3;
    do_push(2, mkpkt(4'd0, 4'd3, 23'h1AA), 1'b1);
    do_push(2, mkpkt(4'd0, 4'd4, 23'h2BB), 1'b1);
    popin[2] = 1'b1;
    popped = 0;
    lows   = 0;
    for (int k = 0; k < 12 && popped < 2; k++) begin
      if (pndng[2]) begin
        check("gap_data", 64'(dout[2*W +: W]), 64'(sb[2].pop_front()));
        popped++;
      end else if (popped == 1) begin
        lows++;
        check("gap_cnt_hold", 64'(cnt(2)), 64'd1);
      end
      tick();
    end
    popin = '0;
    check("gap_popped", 64'(popped), 64'd2);
    check("gap_lows", 64'(lows), 64'd3);
    check("gap_cnt0", 64'(cnt(2)), 64'd0);
    gap = 4'd0;
    for (int k = 0; k < 4; k++) tick();
    check("gap_idle", 64'(pndng[2]), 64'd0);

    // Broadcast destination, 9 packets through a 4-deep FIFO
    for (int k = 0; k < 4; k++) do_push(4, mkpkt(4'hF, 4'hF, 23'(100 + k)), 1'b1);
    check("bc_full", 64'(full[4]), 64'd1);
    for (int k = 0; k < 4; k++) pop_head(4, "bc_d1");
    for (int k = 0; k < 4; k++) do_push(4, mkpkt(4'hF, 4'hF, 23'(200 + k)), 1'b1);
    check("bc_cnt4", 64'(cnt(4)), 64'd4);
    for (int k = 0; k < 4; k++) pop_head(4, "bc_d2");
    do_push(4, mkpkt(4'hF, 4'hF, 23'd300), 1'b1);
    pop_head(4, "bc_d3");
    check("bc_empty", 64'(cnt(4)), 64'd0);
    check("bc_err", 64'(err_cnt), 64'd0);

    // Reset with queued packets and nonzero counters
    for (int k = 0; k < 3; k++) do_push(5, mkpkt(4'd3, 4'd0, 23'(k)), 1'b1);
    do_push(6, mkpkt(4'd9, 4'd9, 23'd1), 1'b0);
    for (int k = 0; k < 4; k++) do_push(7, mkpkt(4'd4, 4'd5, 23'(k)), 1'b1);
    do_push(7, mkpkt(4'd4, 4'd5, 23'd9), 1'b0);
    check("rs_cnt5", 64'(cnt(5)), 64'd3);
    check("rs_err1", 64'(err_cnt), 64'd1);
    check("rs_drop1", 64'(drop_cnt), 64'd1);
    reset    = 1'b1;
    push[5]  = 1'b1;
    popin[5] = 1'b1;
    wr_data[5*W +: W] = mkpkt(4'd3, 4'd0, 23'd55);
    tick();
    reset = 1'b0;
    push  = '0;
    popin = '0;
    for (int t = 0; t < N; t++) sb[t].delete();
    check("rs_cnt0", 64'(cnt(5)), 64'd0);
    check("rs_pnd", 64'(pndng), 64'd0);
    check("rs_full", 64'(full), 64'd0);
    check("rs_err0", 64'(err_cnt), 64'd0);
    check("rs_drop0", 64'(drop_cnt), 64'd0);
    tick();
    check("rs_ignored", 64'(pndng[5]), 64'd0);

    // Multiple simultaneous invalid pushes, then saturation
    push = 16'b0000_0001_1100_0000;
    for (int t = 6; t < 9; t++) wr_data[t*W +: W] = mkpkt(4'd7, 4'd7, 23'd0);
    tick();
    push = '0;
    check("multi_err", 64'(err_cnt), 64'd3);
    do_reset();
    for (int t = 0; t < N; t++) wr_data[t*W +: W] = mkpkt(4'd0, 4'd0, 23'(t));
    push = '1;
    for (int k = 0; k < 15; k++) tick();
    check("sat_err240", 64'(err_cnt), 64'd240);
    tick();
    push = '0;
    check("sat_err255", 64'(err_cnt), 64'd255);
    check("sat_pnd", 64'(pndng), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
